// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//   NUM_CH independent square-wave dividers running from one clk_in.
//   Each channel has a runtime-programmable half-period. A new divisor is held
//   as pending and takes effect only at the channel's next toggle, so the
//   output never produces a shortened or stretched runt half-cycle.
//
// Parameters
//   NUM_CH       number of divider channels (>= 1)
//   CNT_W        counter / divisor width
//   DEFAULT_DIV  half-period loaded into every channel at reset
//
// Ports
//   clk_in   system clock, all logic on posedge
//   reset_n  asynchronous active-low reset
//   div_wr   divisor write strobe (one cycle)
//   div_ch   channel index for the write; out-of-range indices are ignored
//   div_val  new half-period in clk_in cycles (0 behaves as 1)
//   ch_en    per-channel run enable
//   clk_out  divided square waves, registered
//   tick     one-cycle pulse in the first cycle clk_out reads 1
//   busy     divisor update pending on that channel
//
// Build option
//   CLOCK_DIV_TICK_EN  when defined, tick flops are built; otherwise tick is 0.

module clock_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 20000,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset_n,
    input  logic              div_wr,
    input  logic [CH_W-1:0]   div_ch,
    input  logic [CNT_W-1:0]  div_val,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act_div;
        logic [CNT_W-1:0] pend_div;
        logic [CNT_W-1:0] eff;
        logic             pend_vld;
        logic             clk_q;
        logic             wrap;
        logic             wr_hit;
        logic             apply_now;

        always_comb begin
            eff       = (act_div == '0) ? CNT_W'(1) : act_div;
            wrap      = ch_en[g] && (cnt == eff - CNT_W'(1));
            wr_hit    = div_wr && (div_ch == CH_W'(g));
            // A disabled channel has no period in flight, so any new divisor
            // can be taken immediately, exactly as at a wrap.
            apply_now = !ch_en[g] || wrap;
        end

        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                cnt      <= '0;
                act_div  <= CNT_W'(DEFAULT_DIV);
                pend_div <= '0;
                pend_vld <= 1'b0;
                clk_q    <= 1'b0;
            end else begin
                if (!ch_en[g]) begin
                    cnt   <= '0;
                    clk_q <= 1'b0;
                end else if (wrap) begin
                    cnt   <= '0;
                    clk_q <= ~clk_q;
                end else begin
                    cnt   <= cnt + CNT_W'(1);
                end

                // Incoming write beats an older pending value at an apply point.
                if (apply_now) begin
                    if (wr_hit) begin
                        act_div  <= div_val;
                        pend_vld <= 1'b0;
                    end else if (pend_vld) begin
                        act_div  <= pend_div;
                        pend_vld <= 1'b0;
                    end
                end else if (wr_hit) begin
                    pend_div <= div_val;
                    pend_vld <= 1'b1;
                end
            end
        end

        assign clk_out[g] = clk_q;
        assign busy[g]    = pend_vld;

`ifdef CLOCK_DIV_TICK_EN
        logic tick_q;

        // Rising wrap: registered together with clk_q so both read 1 in the same cycle.
        always_ff @(posedge clk_in or negedge reset_n) begin
            if (!reset_n) begin
                tick_q <= 1'b0;
            end else begin
                tick_q <= wrap && !clk_q;
            end
        end

        assign tick[g] = tick_q;
`else
        assign tick[g] = 1'b0;
`endif
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed bench for clock_divider_multi (NUM_CH=4, CNT_W=16, DEFAULT_DIV=4),
// plus a 5-channel instance to exercise an out-of-range write index.

module tb_clock_divider_multi;

    logic        clk_in  = 1'b0;
    logic        reset_n = 1'b1;
    logic        div_wr  = 1'b0;
    logic [1:0]  div_ch  = '0;
    logic [15:0] div_val = '0;
    logic [3:0]  ch_en   = '1;
    logic [3:0]  clk_out;
    logic [3:0]  tick;
    logic [3:0]  busy;

    logic [2:0]  div_ch5 = 3'd5;
    logic [4:0]  ch_en5  = '1;
    logic [4:0]  clk_out5;
    logic [4:0]  tick5;
    logic [4:0]  busy5;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

`ifdef CLOCK_DIV_TICK_EN
    localparam logic [3:0] TK = 4'hF;
`else
    localparam logic [3:0] TK = 4'h0;
`endif

    clock_divider_multi #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(4)) u_dut (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .div_wr  (div_wr),
        .div_ch  (div_ch),
        .div_val (div_val),
        .ch_en   (ch_en),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    clock_divider_multi #(.NUM_CH(5), .CNT_W(16), .DEFAULT_DIV(4)) u_dut5 (
        .clk_in  (clk_in),
        .reset_n (reset_n),
        .div_wr  (div_wr),
        .div_ch  (div_ch5),
        .div_val (div_val),
        .ch_en   (ch_en5),
        .clk_out (clk_out5),
        .tick    (tick5),
        .busy    (busy5)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to #1 after the n-th posedge since reset release.
    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk_in);
            #1;
            cyc++;
        end
    endtask

    task automatic hold_reset();
        reset_n = 1'b0;
        div_wr  = 1'b0;
        ch_en   = '1;
        ch_en5  = '1;
        repeat (2) @(posedge clk_in);
        #1;
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    initial begin
        // A: reset values, default period 8, first rise 4 cycles after release
        hold_reset();
        chk("rst_clk",  {4'h0, clk_out}, 8'h00);
        chk("rst_busy", {4'h0, busy},    8'h00);
        chk("rst_tick", {4'h0, tick},    8'h00);
        release_reset();
        step_to(3);  chk("a_c3",    {4'h0, clk_out}, 8'h00);
        step_to(4);  chk("a_c4",    {4'h0, clk_out}, 8'h0F);
                     chk("a_tick4", {4'h0, tick},    {4'h0, TK});
        step_to(5);  chk("a_tick5", {4'h0, tick},    8'h00);
        step_to(7);  chk("a_c7",    {4'h0, clk_out}, 8'h0F);
        step_to(8);  chk("a_c8",    {4'h0, clk_out}, 8'h00);
        step_to(12); chk("a_c12",   {4'h0, clk_out}, 8'h0F);

        // B: ch1=2 written at cnt=1; current half-cycle keeps 4, then 2
        hold_reset();
        release_reset();
        step_to(1);
        div_wr = 1'b1; div_ch = 2'd1; div_val = 16'd2;
        step_to(2);  div_wr = 1'b0;
                     chk("b_busy2", {4'h0, busy},    8'h02);
        step_to(3);  chk("b_busy3", {4'h0, busy},    8'h02);
                     chk("b_c3",    {4'h0, clk_out}, 8'h00);
        step_to(4);  chk("b_c4",    {4'h0, clk_out}, 8'h0F);
                     chk("b_busy4", {4'h0, busy},    8'h00);
        step_to(6);  chk("b_c6",    {4'h0, clk_out}, 8'h0D);
        step_to(8);  chk("b_c8",    {4'h0, clk_out}, 8'h02);
        step_to(10); chk("b_c10",   {4'h0, clk_out}, 8'h00);
        step_to(12); chk("b_c12",   {4'h0, clk_out}, 8'h0F);

        // C: ch2=0 behaves as 1 -> toggles every cycle after apply
        hold_reset();
        release_reset();
        div_wr = 1'b1; div_ch = 2'd2; div_val = 16'd0;
        step_to(1);  div_wr = 1'b0;
                     chk("c_busy1", {4'h0, busy},    8'h04);
        step_to(4);  chk("c_c4",    {4'h0, clk_out}, 8'h0F);
                     chk("c_busy4", {4'h0, busy},    8'h00);
        step_to(5);  chk("c_c5",    {4'h0, clk_out}, 8'h0B);
        step_to(6);  chk("c_c6",    {4'h0, clk_out}, 8'h0F);
        step_to(7);  chk("c_c7",    {4'h0, clk_out}, 8'h0B);

        // D: ch0=6 written in the wrap cycle -> next half is 6, busy stays low
        hold_reset();
        release_reset();
        step_to(3);
        div_wr = 1'b1; div_ch = 2'd0; div_val = 16'd6;
        step_to(4);  div_wr = 1'b0;
                     chk("d_c4",    {4'h0, clk_out}, 8'h0F);
                     chk("d_busy4", {4'h0, busy},    8'h00);
        step_to(5);  chk("d_busy5", {4'h0, busy},    8'h00);
        step_to(8);  chk("d_c8",    {4'h0, clk_out}, 8'h01);
        step_to(10); chk("d_c10",   {4'h0, clk_out}, 8'h00);
        step_to(12); chk("d_c12",   {4'h0, clk_out}, 8'h0E);
        step_to(16); chk("d_c16",   {4'h0, clk_out}, 8'h01);

        // E: drop ch3 while high at cnt=2, then re-enable
        hold_reset();
        release_reset();
        step_to(6);  ch_en = 4'b0111;
        step_to(7);  chk("e_c7",    {4'h0, clk_out}, 8'h07);
        step_to(8);  chk("e_c8",    {4'h0, clk_out}, 8'h00);
        step_to(9);  chk("e_c9",    {4'h0, clk_out}, 8'h00);
                     ch_en = 4'b1111;
        step_to(12); chk("e_c12",   {4'h0, clk_out}, 8'h07);
        step_to(13); chk("e_c13",   {4'h0, clk_out}, 8'h0F);
                     chk("e_tick13", {4'h0, tick},   {4'h0, TK & 4'b1000});
        // asynchronous reset clears outputs between clock edges
        reset_n = 1'b0;
        #2;
        chk("e_arst_clk", {4'h0, clk_out}, 8'h00);

        // F: out-of-range channel index on the 5-channel instance is ignored
        hold_reset();
        release_reset();
        div_wr = 1'b1; div_ch = 2'd0; div_val = 16'd2;
        step_to(1);  div_wr = 1'b0;
                     chk("f_busy1", {3'h0, busy5},    8'h00);
        step_to(4);  chk("f_c4",    {3'h0, clk_out5}, 8'h1F);
        step_to(5);  chk("f_tick5", {3'h0, tick5},    8'h00);
        step_to(6);  chk("f_c6",    {3'h0, clk_out5}, 8'h1F);
        step_to(8);  chk("f_c8",    {3'h0, clk_out5}, 8'h00);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
